mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Upstream control stage for the 4:1 mux datapath: arbitrates four requesting sources round-robin and drives the mux select lines.
- Holds a granted source for a whole burst, terminated by a per-source last flag, by request withdrawal, or by a beat-limit watchdog.
- Its select output feeds the mux select input directly; grant_valid qualifies it for the downstream consumer.

Parameters:
- MAX_BEATS, 8, maximum beats transferred per grant before forced rotation; legal 1..255.
- CNT_W, $clog2(MAX_BEATS+1), width of the internal beat counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-source request; bit i = source in_i has data.
- last  input  4  per-source last-beat flag; sampled only for the granted source.
- accept  input  1  downstream takes the current beat this cycle.
- select  output  2  mux select, index of granted source.
- grant  output  4  one-hot grant; all-zero when idle.
- grant_valid  output  1  select/grant meaningful this cycle.
- timeout_evt  output  1  one-cycle pulse when a grant is released by the beat limit.

Behaviour:
- One clock; reset is asynchronous, active-low (clk, rst_n).
- Reset (asserted at any time, including mid-burst): select=0, grant=0, grant_valid=0, timeout_evt=0, priority pointer ptr=0, beat counter=0, state IDLE. Outputs clear immediately on rst_n fall, not at the next edge.
- All outputs are registered.
- States:
  - IDLE: grant_valid=0, grant=0, select holds its previous value.
  - GRANT: grant_valid=1, grant=onehot(select).
- IDLE -> GRANT:
  - Triggered by any req bit set at a clock edge.
  - Winner is the first set bit scanning ptr, ptr+1, ... with mod-4 wrap.
  - Next cycle: select=winner, grant=onehot, grant_valid=1, counter=0.
  - Request-to-grant latency is exactly 1 cycle.
- Beat transfer: in GRANT, an edge where accept=1 and req[select]=1; the counter increments by 1.
- Release conditions, evaluated at each GRANT edge, in priority order:
  - (a) Transfer with last[select]=1: normal release, timeout_evt stays 0.
  - (b) Transfer with counter == MAX_BEATS-1 and last[select]=0: forced release, timeout_evt=1 for the next cycle only.
  - (c) req[select]=0: drop release, no transfer counted, timeout_evt stays 0.
- On any release:
  - ptr <= (select+1) mod 4; state <= IDLE; next cycle grant_valid=0, grant=0.
  - Exactly one idle bubble cycle between grants, even if requests are pending.
- Simultaneous last and limit on the same beat: treated as (a); no timeout_evt.
- accept=0 while granted: hold the grant indefinitely; counter unchanged; no timeout (the limit counts beats, not cycles).
- Requests from non-granted sources never disturb the current grant.
- Wrap-around: ptr=3 releasing advances ptr to 0. If only the just-released source is requesting, it is re-granted after the bubble.
- Counter never exceeds MAX_BEATS-1. With MAX_BEATS=1 every transfer releases; timeout_evt fires unless last=1.
- last bits of non-granted sources and accept in IDLE are ignored.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> grant_valid=0, grant=0, select=0, timeout_evt=0 throughout.
- req=4'b1111, accept=1, last=4'b1111 each beat -> grants rotate in0,in1,in2,in3,in0: select 0,1,2,3,0. Each grant_valid pulse lasts 1 cycle, separated by 1-cycle bubbles.
- req[2]=1 only, accept=1, last=0, MAX_BEATS=8 -> select=2 held for exactly 8 transfers. timeout_evt=1 on the cycle after the 8th transfer; then 1-cycle bubble; select=2 re-granted.
- Grant in1; accept toggled 1,0,0,1; last=1 on the 2nd transfer -> release after 2 transfers despite 4 cycles; timeout_evt=0; next grant scans from in2.
- Grant in3 with 3 beats done, then req[3] dropped -> release next edge without timeout; ptr wraps to 0; pending req[0] granted after the bubble.
- Assert rst_n=0 mid-burst between edges -> grant, grant_valid, select clear immediately. After release with req=4'b1010, the first grant is in1 (ptr=0).

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four requesting sources and the round-robin arbiter.
//   req[3:0]     per-source request
//   last[3:0]    per-source last-beat flag
//   accept       downstream takes the current beat
//   select[1:0]  mux select, index of the granted source
//   grant[3:0]   one-hot grant, zero when idle
//   grant_valid  select/grant meaningful this cycle
//   timeout_evt  one-cycle pulse on a beat-limit release
// master: source/consumer side, slave: arbiter side.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       accept;
  logic [1:0] select;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout_evt;

  modport master (
    output req, last, accept,
    input  select, grant, grant_valid, timeout_evt
  );

  modport slave (
    input  req, last, accept,
    output select, grant, grant_valid, timeout_evt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the 4:1 mux datapath. Holds a granted source for a
// whole burst, released by last, request withdrawal or the beat-limit watchdog.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   arb    arbiter side of mux_rr_arbiter_if (req/last/accept in,
//          select/grant/grant_valid/timeout_evt out, all registered)
//
// state | meaning
// IDLE  | no grant; select keeps its last value; one cycle bubble after release
// GRANT | source 'select' owns the mux until last, drop or beat limit
module mux_rr_arbiter #(
  parameter  int MAX_BEATS = 8,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input logic            clk,
  input logic            rst_n,
  mux_rr_arbiter_if.slave arb
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic             gv_q, gv_d;
  logic             tevt_q, tevt_d;

  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic             win_found;
  logic             xfer;
  logic             release_now;

  assign xfer = arb.accept & arb.req[sel_q];

  // First requesting source scanning from ptr with mod-4 wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && arb.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    gv_d        = gv_q;
    tevt_d      = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        gv_d    = 1'b0;
        grant_d = '0;
        if (win_found) begin
          state_d = GRANT;
          sel_d   = win_idx;
          cnt_d   = '0;
          gv_d    = 1'b1;
          grant_d = 4'(1) << win_idx;
        end
      end
      GRANT: begin
        // last wins over the limit when both land on the same beat
        if (xfer && arb.last[sel_q]) begin
          release_now = 1'b1;
        end else if (xfer && (cnt_q == CNT_LIMIT)) begin
          release_now = 1'b1;
          tevt_d      = 1'b1;
        end else if (!arb.req[sel_q]) begin
          release_now = 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
          gv_d    = 1'b0;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gv_d    = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gv_q    <= 1'b0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      tevt_q  <= tevt_d;
    end
  end

  assign arb.select      = sel_q;
  assign arb.grant       = grant_q;
  assign arb.grant_valid = gv_q;
  assign arb.timeout_evt = tevt_q;

endmodule
